rs_hs_pipeline_arbiter: RTL and testbench
=========================================

# rs_hs_pipeline_arbiter

Round-robin, packet-locked N-to-1 arbiter that shares one relay-station handshake pipeline (head/body/tail chain) between `NUM_REQ` requesters. Each accepted beat is tagged with its source ID and last flag and registered into a single output stage that drives the pipeline head. A credit counter sized to the tail FIFO prevents the arbiter from injecting more words than the far end can absorb. The block sits directly in front of the pipeline's head region, in the same clock domain.

## Interface
- `DATA_WIDTH`, 32, payload bits per beat
- `NUM_REQ`, 4, number of requesters (2..16)
- `ID_WIDTH`, `$clog2(NUM_REQ)`, source-tag width
- `CREDITS`, 24, initial and maximum credit count; equals the tail FIFO's usable depth
- `CREDIT_WIDTH`, `$clog2(CREDITS+1)`, credit counter width

- `clk`  in  1  sole clock
- `reset`  in  1  asynchronous, active-high reset
- `req_valid`  in  NUM_REQ  per-requester beat valid
- `req_last`  in  NUM_REQ  per-requester last-beat-of-packet flag
- `req_data`  in  NUM_REQ*DATA_WIDTH  requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
- `req_ready`  out  NUM_REQ  per-requester accept, one-hot or zero
- `pp_valid`  out  1  registered valid into pipeline head
- `pp_data`  out  DATA_WIDTH+ID_WIDTH+1  {id, last, data}: data in [DATA_WIDTH-1:0], last at [DATA_WIDTH], id above
- `pp_ready`  in  1  pipeline head ready
- `credit_return`  in  1  one pulse per word drained from the tail FIFO
- `credits`  out  CREDIT_WIDTH  current credit count
- `credit_err`  out  1  sticky: credit return received while already at `CREDITS`

## Operation
- Accept condition `acc = (!pp_valid || pp_ready) && credits != 0 && winner valid`. On `acc`: `req_ready[winner]` = 1, beat loaded into output register, `pp_valid` <= 1. If `pp_valid && pp_ready && !acc`, `pp_valid` <= 0.
- FSM states: IDLE, LOCKED.
  - IDLE: winner = first requester with `req_valid` scanning ptr+1, ptr+2, … cyclically through NUM_REQ. On `acc` with `req_last`=1: stay IDLE, ptr <= winner. On `acc` with `req_last`=0: go LOCKED, gnt <= winner.
  - LOCKED: winner = gnt only; other requesters ignored regardless of valid. On `acc` with `req_last`=1: go IDLE, ptr <= gnt.
- `req_ready` depends combinationally on `req_valid`, state, `pp_valid`, `pp_ready` and `credits`; it never asserts for a requester whose valid is low.
- Credits: `acc` alone decrements by 1; `credit_return` alone increments by 1; both in the same cycle leaves count unchanged. `credit_return` at `credits == CREDITS` (without `acc`): count holds at `CREDITS`, `credit_err` <= 1 until reset.
- Zero credits stalls all requesters, including a LOCKED packet mid-burst; the lock is retained.
- Reset values: state IDLE, ptr = NUM_REQ-1 (requester 0 wins first), gnt = 0, `pp_valid` = 0, `pp_data` = 0, `credits` = CREDITS, `credit_err` = 0, `req_ready` = 0.
- Reset asserted mid-packet abandons the packet; the pipeline downstream is reset by the same signal.

## Timing
- Latency: beat accepted in cycle N appears on `pp_valid`/`pp_data` in cycle N+1.
- Full throughput: one beat per cycle while `pp_ready`=1 and credits > 0.
- `pp_valid`/`pp_data` hold stable while `pp_valid && !pp_ready`.
- Credit taken at accept, so `credits` reflects the beat in the output register.
- Round-robin fairness: a continuously valid requester is granted within NUM_REQ-1 packets of others.

## Configuration
- `RS_HS_ARB_STATS_EN` defined: adds output `stall_cycles` [31:0], which counts cycles where any `req_valid` is high and `credits == 0`. It resets to 0 and saturates at 0xFFFFFFFF.
- `RS_HS_ARB_STATS_EN` undefined: port and counter are absent. All other behaviour is identical.

## Test plan
- Reset, then all four requesters valid with single-beat packets, `pp_ready`=1, `credit_return` looped back after 3 cycles. Required: grant order 0,1,2,3,0…; `pp_data` ids match this order; each beat is output one cycle after `req_ready`.
- Requester 2 sends 5-beat packet (last on beat 5) while 0 and 3 are valid. Required: 5 consecutive id=2 beats with no interleave, then requester 3, then requester 0.
- `CREDITS`=24, no `credit_return`, requester 1 streaming. Required: exactly 24 beats accepted, `credits`=0, `req_ready`=0. One `credit_return` pulse then allows exactly one more beat.
- `pp_ready` held low 4 cycles with `pp_valid`=1. Required: `pp_data` is unchanged, `req_ready`=0 throughout, and there is no credit change.
- Simultaneous `acc` and `credit_return` at `credits`=10. Required: `credits` stays 10. A `credit_return` at `credits`=24 sets `credit_err`=1, which stays set until reset.
- With `RS_HS_ARB_STATS_EN`: stall 7 cycles at zero credits with requester 0 valid. Required: `stall_cycles`=7. Assert reset mid-packet. Required: all reset values restored and the next grant goes to requester 0.

Source files
------------

// File: rtl/rs_hs_pipeline_arbiter_if.sv
// Requester/pipeline-head bundle for rs_hs_pipeline_arbiter.
// slave = arbiter side, master = requesters + pipeline side.
interface rs_hs_pipeline_arbiter_if #(
  parameter int DATA_WIDTH   = 32,
  parameter int NUM_REQ      = 4,
  parameter int ID_WIDTH     = $clog2(NUM_REQ),
  parameter int CREDIT_WIDTH = 5
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_last;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          pp_valid;
  logic [DATA_WIDTH+ID_WIDTH:0]  pp_data;
  logic                          pp_ready;
  logic                          credit_return;
  logic [CREDIT_WIDTH-1:0]       credits;
  logic                          credit_err;

  modport slave (
    input  req_valid,
    input  req_last,
    input  req_data,
    output req_ready,
    output pp_valid,
    output pp_data,
    input  pp_ready,
    input  credit_return,
    output credits,
    output credit_err
  );

  modport master (
    output req_valid,
    output req_last,
    output req_data,
    input  req_ready,
    input  pp_valid,
    input  pp_data,
    output pp_ready,
    output credit_return,
    input  credits,
    input  credit_err
  );
endinterface

// File: rtl/rs_hs_pipeline_arbiter.sv
// Round-robin packet-locked N:1 arbiter with credit gate feeding a
// relay-station pipeline head through one registered output stage.
// Ports: clk, reset (async, active-high), bus (slave modport:
//   req_valid/last/data/ready, pp_valid/data/ready, credit_return,
//   credits, credit_err).
// Option RS_HS_ARB_STATS_EN adds stall_cycles[31:0]: cycles with any
//   request pending while credits are zero (saturating).
module rs_hs_pipeline_arbiter #(
  parameter int DATA_WIDTH   = 32,
  parameter int NUM_REQ      = 4,
  parameter int ID_WIDTH     = $clog2(NUM_REQ),
  parameter int CREDITS      = 24,
  parameter int CREDIT_WIDTH = $clog2(CREDITS+1)
) (
  input  logic clk,
  input  logic reset,
  rs_hs_pipeline_arbiter_if.slave bus
`ifdef RS_HS_ARB_STATS_EN
  ,
  output logic [31:0] stall_cycles
`endif
);

  typedef enum logic {IDLE, LOCKED} state_t;

  localparam logic [CREDIT_WIDTH-1:0] CRED_MAX =
    CREDIT_WIDTH'(CREDITS);

  state_t                    state, state_nxt;
  logic [ID_WIDTH-1:0]       ptr, ptr_nxt;
  logic [ID_WIDTH-1:0]       gnt, gnt_nxt;
  logic [ID_WIDTH-1:0]       win_id;
  logic [ID_WIDTH-1:0]       cand;
  logic                      win_vld;
  logic                      win_last;
  logic [DATA_WIDTH-1:0]     win_data;
  logic                      acc;
  logic [NUM_REQ-1:0]        ready;
  logic                      out_vld;
  logic [DATA_WIDTH+ID_WIDTH:0] out_data;
  logic [CREDIT_WIDTH-1:0]   cred;
  logic                      cred_err;

  // IDLE: first valid requester after ptr, cyclically.
  // LOCKED: only the owner of the open packet.
  always_comb begin
    win_vld = 1'b0;
    win_id  = '0;
    cand    = '0;
    if (state == LOCKED) begin
      win_id  = gnt;
      win_vld = bus.req_valid[gnt];
    end else begin
      for (int k = 1; k <= NUM_REQ; k++) begin
        cand = ID_WIDTH'((int'(ptr) + k) % NUM_REQ);
        if (!win_vld && bus.req_valid[cand]) begin
          win_vld = 1'b1;
          win_id  = cand;
        end
      end
    end
  end

  assign win_last = bus.req_last[win_id];
  assign win_data =
    bus.req_data[int'(win_id)*DATA_WIDTH +: DATA_WIDTH];

  // No handshake while reset is held, so no beat is
  // acknowledged that the register stage will never capture.
  assign acc = !reset
            && (!out_vld || bus.pp_ready)
            && (cred != '0)
            && win_vld;

  always_comb begin
    ready = '0;
    if (acc) ready[win_id] = 1'b1;
  end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    gnt_nxt   = gnt;
    unique case (state)
      IDLE: begin
        if (acc) begin
          if (win_last) begin
            ptr_nxt = win_id;
          end else begin
            state_nxt = LOCKED;
            gnt_nxt   = win_id;
          end
        end
      end
      LOCKED: begin
        if (acc && win_last) begin
          state_nxt = IDLE;
          ptr_nxt   = gnt;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      ptr      <= ID_WIDTH'(NUM_REQ-1);
      gnt      <= '0;
      out_vld  <= 1'b0;
      out_data <= '0;
      cred     <= CRED_MAX;
      cred_err <= 1'b0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      gnt   <= gnt_nxt;
      if (acc) begin
        out_vld  <= 1'b1;
        out_data <= {win_id, win_last, win_data};
      end else if (bus.pp_ready) begin
        out_vld  <= 1'b0;
      end
      unique case ({acc, bus.credit_return})
        2'b10: cred <= cred - 1'b1;
        2'b01: begin
          if (cred == CRED_MAX) cred_err <= 1'b1;
          else                  cred     <= cred + 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef RS_HS_ARB_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cycles <= '0;
    end else if (|bus.req_valid && cred == '0
                 && stall_cycles != '1) begin
      stall_cycles <= stall_cycles + 1'b1;
    end
  end
`endif

  assign bus.req_ready  = ready;
  assign bus.pp_valid   = out_vld;
  assign bus.pp_data    = out_data;
  assign bus.credits    = cred;
  assign bus.credit_err = cred_err;

endmodule

// File: tb/tb_rs_hs_pipeline_arbiter.sv
// Directed bench for rs_hs_pipeline_arbiter: round robin, packet
// lock, credit exhaustion, backpressure, credit edge cases, reset.
module tb_rs_hs_pipeline_arbiter;
  localparam int DW = 32;
  localparam int NR = 4;
  localparam int IW = 2;
  localparam int CR = 24;
  localparam int CW = 5;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   vecs = 0;
  int   errs = 0;

  rs_hs_pipeline_arbiter_if #(
    .DATA_WIDTH(DW), .NUM_REQ(NR),
    .ID_WIDTH(IW), .CREDIT_WIDTH(CW)
  ) bus ();

`ifdef RS_HS_ARB_STATS_EN
  logic [31:0] stall_cycles;
`endif

  rs_hs_pipeline_arbiter #(
    .DATA_WIDTH(DW), .NUM_REQ(NR), .ID_WIDTH(IW),
    .CREDITS(CR), .CREDIT_WIDTH(CW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
`ifdef RS_HS_ARB_STATS_EN
    ,
    .stall_cycles(stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  task automatic idle_inputs();
    bus.req_valid     = '0;
    bus.req_last      = '0;
    bus.req_data      = '0;
    bus.pp_ready      = 1'b1;
    bus.credit_return = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    vecs++;
    if (bus.pp_valid !== 1'b0) begin
      errs++;
      $display("FAIL rst_pp_valid got %0b exp 0", bus.pp_valid);
    end
    vecs++;
    if (bus.pp_data !== '0) begin
      errs++;
      $display("FAIL rst_pp_data got %h exp 0", bus.pp_data);
    end
    vecs++;
    if (bus.credits !== 5'd24) begin
      errs++;
      $display("FAIL rst_credits got %0d exp 24", bus.credits);
    end
    vecs++;
    if (bus.credit_err !== 1'b0) begin
      errs++;
      $display("FAIL rst_credit_err got %0b exp 0",
               bus.credit_err);
    end
    vecs++;
    if (bus.req_ready !== 4'b0000) begin
      errs++;
      $display("FAIL rst_req_ready got %b exp 0000",
               bus.req_ready);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_round_robin();
    logic [2:0]    hist = '0;
    int            exp_cred = 24;
    logic [IW-1:0] pid = '0;
    logic [DW-1:0] pd;
    logic [3:0]    exp_rdy;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (c > 0) begin
        pd = 32'hA000_0000 + DW'(pid);
        vecs++;
        if (bus.pp_valid !== 1'b1
            || bus.pp_data !== {pid, 1'b1, pd}) begin
          errs++;
          $display("FAIL rr_beat c=%0d got v=%0b %h exp %h",
                   c, bus.pp_valid, bus.pp_data,
                   {pid, 1'b1, pd});
        end
      end
      vecs++;
      if (bus.credits !== CW'(exp_cred)) begin
        errs++;
        $display("FAIL rr_credits c=%0d got %0d exp %0d",
                 c, bus.credits, exp_cred);
      end
      bus.req_valid = 4'hF;
      bus.req_last  = 4'hF;
      for (int i = 0; i < NR; i++)
        bus.req_data[i*DW +: DW] = 32'hA000_0000 + i;
      bus.credit_return = hist[2];
      #1;
      exp_rdy = 4'b0001 << (c % 4);
      vecs++;
      if (bus.req_ready !== exp_rdy) begin
        errs++;
        $display("FAIL rr_grant c=%0d got %b exp %b",
                 c, bus.req_ready, exp_rdy);
      end
      if (!hist[2]) exp_cred--;
      hist = {hist[1:0], 1'b1};
      pid  = IW'(c % 4);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (c == 0) begin
        pd = 32'hA000_0000 + DW'(pid);
        vecs++;
        if (bus.pp_data !== {pid, 1'b1, pd}) begin
          errs++;
          $display("FAIL rr_last_beat got %h exp %h",
                   bus.pp_data, {pid, 1'b1, pd});
        end
      end
      bus.req_valid     = '0;
      bus.credit_return = hist[2];
      if (hist[2]) exp_cred++;
      hist = {hist[1:0], 1'b0};
    end
    @(negedge clk);
    bus.credit_return = 1'b0;
    vecs++;
    if (bus.credits !== 5'd24 || bus.pp_valid !== 1'b0) begin
      errs++;
      $display("FAIL rr_drain got cred=%0d v=%0b exp 24 0",
               bus.credits, bus.pp_valid);
    end
  endtask

  task automatic test_locked();
    logic [3:0]         exp_rdy;
    logic [DW+IW:0]     exp_pd = '0;
    logic [DW+IW:0]     nxt_pd;
    // single beat from requester 1 moves ptr to 1
    @(negedge clk);
    bus.req_valid = 4'b0010;
    bus.req_last  = 4'b0010;
    bus.req_data[1*DW +: DW] = 32'h1111_0000;
    #1;
    vecs++;
    if (bus.req_ready !== 4'b0010) begin
      errs++;
      $display("FAIL lk_pre got %b exp 0010", bus.req_ready);
    end
    exp_pd = {2'd1, 1'b1, 32'h1111_0000};
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      vecs++;
      if (bus.pp_data !== exp_pd) begin
        errs++;
        $display("FAIL lk_beat k=%0d got %h exp %h",
                 k, bus.pp_data, exp_pd);
      end
      bus.req_data[0*DW +: DW] = 32'hD000_0000;
      bus.req_data[3*DW +: DW] = 32'hD333_0000;
      bus.req_data[2*DW +: DW] = 32'h2000_0000 + k;
      if (k < 5) begin
        bus.req_valid = 4'b1101;
        bus.req_last  = {1'b1, k == 4, 1'b0, 1'b1};
        exp_rdy = 4'b0100;
        nxt_pd  = {2'd2, k == 4, 32'h2000_0000 + DW'(k)};
      end else if (k == 5) begin
        bus.req_valid = 4'b1001;
        bus.req_last  = 4'b1001;
        exp_rdy = 4'b1000;
        nxt_pd  = {2'd3, 1'b1, 32'hD333_0000};
      end else begin
        bus.req_valid = 4'b0001;
        bus.req_last  = 4'b0001;
        exp_rdy = 4'b0001;
        nxt_pd  = {2'd0, 1'b1, 32'hD000_0000};
      end
      #1;
      vecs++;
      if (bus.req_ready !== exp_rdy) begin
        errs++;
        $display("FAIL lk_grant k=%0d got %b exp %b",
                 k, bus.req_ready, exp_rdy);
      end
      exp_pd = nxt_pd;
    end
    @(negedge clk);
    bus.req_valid = '0;
    vecs++;
    if (bus.pp_data !== exp_pd || bus.credits !== 5'd16) begin
      errs++;
      $display("FAIL lk_end got %h cred=%0d exp %h 16",
               bus.pp_data, bus.credits, exp_pd);
    end
  endtask

  task automatic test_credit_exhaust();
    int n_acc = 0;
    do_reset();
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      bus.req_valid = 4'b0010;
      bus.req_last  = 4'b0010;
      bus.req_data[1*DW +: DW] = DW'(c);
      #1;
      if (bus.req_ready == 4'b0010) n_acc++;
    end
    @(negedge clk);
    bus.req_last = 4'b0000;
    bus.req_data[1*DW +: DW] = 32'hC0DE_0001;
    bus.credit_return = 1'b1;
    #1;
    vecs++;
    if (n_acc != 24) begin
      errs++;
      $display("FAIL cx_count got %0d exp 24", n_acc);
    end
    vecs++;
    if (bus.credits !== 5'd0 || bus.req_ready !== 4'b0) begin
      errs++;
      $display("FAIL cx_zero got cred=%0d rdy=%b exp 0 0000",
               bus.credits, bus.req_ready);
    end
    @(negedge clk);
    bus.credit_return = 1'b0;
    #1;
    vecs++;
    if (bus.credits !== 5'd1 || bus.req_ready !== 4'b0010) begin
      errs++;
      $display("FAIL cx_one got cred=%0d rdy=%b exp 1 0010",
               bus.credits, bus.req_ready);
    end
    @(negedge clk);
    bus.req_valid = 4'b0011;
    bus.req_last  = 4'b0011;
    bus.req_data[1*DW +: DW] = 32'hC0DE_0002;
    #1;
    vecs++;
    if (bus.credits !== 5'd0 || bus.req_ready !== 4'b0) begin
      errs++;
      $display("FAIL cx_stall got cred=%0d rdy=%b exp 0 0000",
               bus.credits, bus.req_ready);
    end
    vecs++;
    if (bus.pp_data !== {2'd1, 1'b0, 32'hC0DE_0001}) begin
      errs++;
      $display("FAIL cx_lock_beat got %h", bus.pp_data);
    end
    bus.credit_return = 1'b1;
    @(negedge clk);
    bus.credit_return = 1'b0;
    #1;
    vecs++;
    if (bus.req_ready !== 4'b0010) begin
      errs++;
      $display("FAIL cx_lock_kept got %b exp 0010",
               bus.req_ready);
    end
    @(negedge clk);
    bus.req_valid = '0;
  endtask

  task automatic test_backpressure();
    logic [DW+IW:0] held;
    do_reset();
    @(negedge clk);
    bus.req_valid = 4'b0001;
    bus.req_last  = 4'b0001;
    bus.req_data[0*DW +: DW] = 32'hBEEF_0000;
    #1;
    vecs++;
    if (bus.req_ready !== 4'b0001) begin
      errs++;
      $display("FAIL bp_first got %b exp 0001", bus.req_ready);
    end
    held = {2'd0, 1'b1, 32'hBEEF_0000};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.req_valid = 4'b0010;
      bus.req_last  = 4'b0010;
      bus.req_data[1*DW +: DW] = 32'hBEEF_0001;
      bus.pp_ready  = 1'b0;
      #1;
      vecs++;
      if (bus.pp_valid !== 1'b1 || bus.pp_data !== held
          || bus.req_ready !== 4'b0
          || bus.credits !== 5'd23) begin
        errs++;
        $display("FAIL bp_hold i=%0d got v=%0b %h rdy=%b c=%0d",
                 i, bus.pp_valid, bus.pp_data,
                 bus.req_ready, bus.credits);
      end
    end
    @(negedge clk);
    bus.pp_ready = 1'b1;
    #1;
    vecs++;
    if (bus.req_ready !== 4'b0010 || bus.pp_data !== held) begin
      errs++;
      $display("FAIL bp_release got rdy=%b %h exp 0010 %h",
               bus.req_ready, bus.pp_data, held);
    end
    @(negedge clk);
    bus.req_valid = '0;
    vecs++;
    if (bus.pp_data !== {2'd1, 1'b1, 32'hBEEF_0001}
        || bus.credits !== 5'd22) begin
      errs++;
      $display("FAIL bp_next got %h cred=%0d",
               bus.pp_data, bus.credits);
    end
  endtask

  task automatic test_credit_simul();
    do_reset();
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      bus.req_valid = 4'b1000;
      bus.req_last  = 4'b1000;
    end
    @(negedge clk);
    bus.credit_return = 1'b1;
    #1;
    vecs++;
    if (bus.credits !== 5'd10 || bus.req_ready !== 4'b1000) begin
      errs++;
      $display("FAIL cs_pre got cred=%0d rdy=%b exp 10 1000",
               bus.credits, bus.req_ready);
    end
    @(negedge clk);
    vecs++;
    if (bus.credits !== 5'd10) begin
      errs++;
      $display("FAIL cs_simul got %0d exp 10", bus.credits);
    end
    bus.req_valid = '0;
    repeat (14) @(negedge clk);
    bus.credit_return = 1'b0;
    #1;
    vecs++;
    if (bus.credits !== 5'd24 || bus.credit_err !== 1'b0) begin
      errs++;
      $display("FAIL cs_full got cred=%0d err=%0b exp 24 0",
               bus.credits, bus.credit_err);
    end
    bus.credit_return = 1'b1;
    @(negedge clk);
    bus.credit_return = 1'b0;
    #1;
    vecs++;
    if (bus.credits !== 5'd24 || bus.credit_err !== 1'b1) begin
      errs++;
      $display("FAIL cs_over got cred=%0d err=%0b exp 24 1",
               bus.credits, bus.credit_err);
    end
    repeat (3) @(negedge clk);
    vecs++;
    if (bus.credit_err !== 1'b1) begin
      errs++;
      $display("FAIL cs_sticky got %0b exp 1", bus.credit_err);
    end
  endtask

  task automatic test_reset_midpacket();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      bus.req_valid = 4'b0100;
      bus.req_last  = 4'b0000;
      bus.req_data[2*DW +: DW] = 32'h2222_0000 + i;
      #1;
      vecs++;
      if (bus.req_ready !== 4'b0100) begin
        errs++;
        $display("FAIL rm_beat i=%0d got %b exp 0100",
                 i, bus.req_ready);
      end
    end
    @(negedge clk);
    bus.req_valid = 4'b0101;
    bus.req_last  = 4'b0101;
    bus.req_data[0*DW +: DW] = 32'h0000_0ABC;
    #2;
    reset = 1'b1;
    #1;
    vecs++;
    if (bus.pp_valid !== 1'b0 || bus.pp_data !== '0
        || bus.credits !== 5'd24 || bus.credit_err !== 1'b0
        || bus.req_ready !== 4'b0) begin
      errs++;
      $display("FAIL rm_vals got v=%0b %h c=%0d e=%0b r=%b",
               bus.pp_valid, bus.pp_data, bus.credits,
               bus.credit_err, bus.req_ready);
    end
`ifdef RS_HS_ARB_STATS_EN
    vecs++;
    if (stall_cycles !== 32'd0) begin
      errs++;
      $display("FAIL rm_stall got %0d exp 0", stall_cycles);
    end
`endif
    @(negedge clk);
    reset = 1'b0;
    #1;
    vecs++;
    if (bus.req_ready !== 4'b0001) begin
      errs++;
      $display("FAIL rm_grant got %b exp 0001", bus.req_ready);
    end
    @(negedge clk);
    bus.req_valid = '0;
    vecs++;
    if (bus.pp_data !== {2'd0, 1'b1, 32'h0000_0ABC}) begin
      errs++;
      $display("FAIL rm_out got %h", bus.pp_data);
    end
  endtask

`ifdef RS_HS_ARB_STATS_EN
  task automatic test_stats();
    do_reset();
    bus.req_valid = 4'b0001;
    bus.req_last  = 4'b0001;
    repeat (24) @(negedge clk);
    vecs++;
    if (bus.credits !== 5'd0 || stall_cycles !== 32'd0) begin
      errs++;
      $display("FAIL st_pre got cred=%0d st=%0d exp 0 0",
               bus.credits, stall_cycles);
    end
    repeat (7) @(negedge clk);
    bus.req_valid = '0;
    vecs++;
    if (stall_cycles !== 32'd7) begin
      errs++;
      $display("FAIL st_count got %0d exp 7", stall_cycles);
    end
    @(negedge clk);
    vecs++;
    if (stall_cycles !== 32'd7) begin
      errs++;
      $display("FAIL st_idle got %0d exp 7", stall_cycles);
    end
  endtask
`endif

  initial begin
    idle_inputs();
    test_reset();
    test_round_robin();
    test_locked();
    test_credit_exhaust();
    test_backpressure();
    test_credit_simul();
    test_reset_midpacket();
`ifdef RS_HS_ARB_STATS_EN
    test_stats();
`endif
    $display("== %0d vectors applied, %0d miscompares ==",
             vecs, errs);
    $finish;
  end
endmodule
